// File: rtl/draw_sprite.sv
// Sprite blitter: copies one SPR_DIM x SPR_DIM sprite from the image ROM into the
// linear frame buffer, skipping transparent pixels and pixels beyond the buffer end.
module draw_sprite #(
  parameter int               SPR_DIM     = 16,
  parameter int               SCREEN_W    = 320,
  parameter int               FB_DEPTH    = 76800,
  parameter int               PIX_W       = 8,
  parameter logic [PIX_W-1:0] TRANSPARENT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             draw_sprite_start,
  input  logic [7:0]       draw_sprite_image,
  input  logic [16:0]      draw_sprite_coordinates,
  output logic             draw_sprite_rdy,
  output logic             draw_done,
  output logic [15:0]      rom_addr,
  input  logic [PIX_W-1:0] rom_rdata,
  output logic             fb_we,
  output logic [16:0]      fb_addr,
  output logic [PIX_W-1:0] fb_data,
  input  logic             fb_busy
);
  localparam int CW = $clog2(SPR_DIM);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      image;
  logic [CW-1:0]   row, col;
  logic [17:0]     row_base, pa;
  logic            need_write, retire, last, col_end;

  // 18-bit sum so a sprite hanging off the bottom of the buffer still compares correctly
  assign pa         = row_base + 18'(col);
  assign need_write = (rom_rdata != TRANSPARENT) && (pa < 18'(FB_DEPTH));
  assign col_end    = (col == CW'(SPR_DIM - 1));
  assign last       = col_end && (row == CW'(SPR_DIM - 1));
  assign rom_addr   = {image, row, col};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    draw_sprite_rdy = 1'b0;
    draw_done       = 1'b0;
    fb_we           = 1'b0;
    fb_addr         = '0;
    fb_data         = '0;
    retire          = 1'b0;
    case (state)
      IDLE: begin
        draw_sprite_rdy = 1'b1;
        if (draw_sprite_start) state_nxt = FETCH;
      end
      FETCH: state_nxt = WRITE;
      WRITE: begin
        fb_addr = pa[16:0];
        fb_data = rom_rdata;
        fb_we   = need_write && !fb_busy;
        // a blocked opaque pixel holds everything and retries next cycle
        retire  = !(need_write && fb_busy);
        if (retire) begin
          draw_done = last;
          state_nxt = last ? IDLE : FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image    <= '0;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
    end else if (state == IDLE && draw_sprite_start) begin
      image    <= draw_sprite_image;
      row      <= '0;
      col      <= '0;
      row_base <= {1'b0, draw_sprite_coordinates};
    end else if (retire) begin
      if (col_end) begin
        col      <= '0;
        row      <= row + CW'(1);
        row_base <= row_base + 18'(SCREEN_W);
      end else begin
        col      <= col + CW'(1);
      end
    end
  end
endmodule
